core2wb_bridge: RTL and testbench



---
 rtl/core2wb_bridge_pkg.sv | 10 +
 rtl/core2wb_bridge.sv | 114 +++++++++++
 tb/tb_core2wb_bridge.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/core2wb_bridge_pkg.sv
// Purpose : shared widths and limits for the core-to-Wishbone master bridge.
// Contents: default address/data widths (matching the wb_if widths) and the
//           default number of accepted-but-unanswered transactions.
package core2wb_bridge_pkg;

  localparam int unsigned C2W_AW        = 32;
  localparam int unsigned C2W_DW        = 32;
  localparam int unsigned C2W_MAX_OUTST = 2;

endpackage : core2wb_bridge_pkg

// File: rtl/core2wb_bridge.sv
// Purpose : converts the core request/grant/rvalid data interface (in-order
//           responses) into a pipelined Wishbone B4 master with up to
//           MAX_OUTST transactions in flight.
// Ports   :
//   clk, rst_n                          clock, synchronous active-low reset
//   core_req/we/addr/be/wdata    (in)   core request channel
//   core_gnt                     (out)  request accepted this cycle (comb.)
//   core_rvalid/rdata/err        (out)  response channel (comb.)
//   wb_cyc/stb/we/adr/sel/dat_o  (out)  Wishbone master request
//   wb_stall/ack/err/dat_i       (in)   Wishbone slave response
module core2wb_bridge
  import core2wb_bridge_pkg::*;
#(
  parameter int unsigned AW        = C2W_AW,
  parameter int unsigned DW        = C2W_DW,
  parameter int unsigned MAX_OUTST = C2W_MAX_OUTST
) (
  input  logic            clk,
  input  logic            rst_n,
  // core side
  input  logic            core_req,
  output logic            core_gnt,
  input  logic            core_we,
  input  logic [AW-1:0]   core_addr,
  input  logic [DW/8-1:0] core_be,
  input  logic [DW-1:0]   core_wdata,
  output logic            core_rvalid,
  output logic [DW-1:0]   core_rdata,
  output logic            core_err,
  // Wishbone side
  output logic            wb_cyc,
  output logic            wb_stb,
  output logic            wb_we,
  output logic [AW-1:0]   wb_adr,
  output logic [DW/8-1:0] wb_sel,
  output logic [DW-1:0]   wb_dat_o,
  input  logic            wb_stall,
  input  logic            wb_ack,
  input  logic            wb_err,
  input  logic [DW-1:0]   wb_dat_i
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = $clog2(MAX_OUTST + 1);

  // request register
  logic          r_stb;
  logic          r_we;
  logic [AW-1:0] r_adr;
  logic [SW-1:0] r_sel;
  logic [DW-1:0] r_dat;

  // issued on the bus, not yet terminated
  logic [CW-1:0] r_out_cnt;

  logic          w_issue;
  logic          w_term;
  logic          w_gnt;
  logic [CW:0]   w_pending;

  // one extra bit so the queued strobe cannot wrap the sum
  assign w_pending = {1'b0, r_out_cnt} + (CW+1)'(r_stb);
  assign w_issue   = r_stb & ~wb_stall;
  // terminations with nothing outstanding are spurious and dropped
  assign w_term    = (wb_ack | wb_err) & (r_out_cnt != '0);
  assign w_gnt     = core_req & (~r_stb | ~wb_stall)
                   & (w_pending < (CW+1)'(MAX_OUTST));

  // Request register: load on grant, drop strobe once the slave takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stb <= 1'b0;
      r_we  <= 1'b0;
      r_adr <= '0;
      r_sel <= '0;
      r_dat <= '0;
    end else if (w_gnt) begin
      r_stb <= 1'b1;
      r_we  <= core_we;
      r_adr <= core_addr;
      r_sel <= core_be;
      r_dat <= core_wdata;
    end else if (w_issue) begin
      r_stb <= 1'b0;
    end
  end

  // Outstanding counter: issue and termination in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_cnt <= '0;
    end else begin
      case ({w_issue, w_term})
        2'b10:   r_out_cnt <= r_out_cnt + CW'(1);
        2'b01:   r_out_cnt <= r_out_cnt - CW'(1);
        default: r_out_cnt <= r_out_cnt;
      endcase
    end
  end

  assign core_gnt    = w_gnt;
  assign core_rvalid = w_term;
  assign core_rdata  = wb_dat_i;
  // ack and err together count as one error termination
  assign core_err    = wb_err;

  assign wb_cyc   = r_stb | (r_out_cnt != '0);
  assign wb_stb   = r_stb;
  assign wb_we    = r_we;
  assign wb_adr   = r_adr;
  assign wb_sel   = r_sel;
  assign wb_dat_o = r_dat;

endmodule : core2wb_bridge

// File: tb/tb_core2wb_bridge.sv
// Purpose : directed self-checking bench for core2wb_bridge; expected
//           responses are queued at grant time and checked on core_rvalid.
module tb_core2wb_bridge;

  logic        clk;
  logic        rst_n;
  logic        core_req;
  logic        core_gnt;
  logic        core_we;
  logic [31:0] core_addr;
  logic [3:0]  core_be;
  logic [31:0] core_wdata;
  logic        core_rvalid;
  logic [31:0] core_rdata;
  logic        core_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_o;
  logic        wb_stall;
  logic        wb_ack;
  logic        wb_err;
  logic [31:0] wb_dat_i;

  int n_tests = 0;
  int n_fail  = 0;
  int n_push  = 0;
  int n_rv    = 0;

  // {err, rdata}
  logic [32:0] exp_q[$];

  core2wb_bridge dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_req   (core_req),
    .core_gnt   (core_gnt),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_be    (core_be),
    .core_wdata (core_wdata),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .core_err   (core_err),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_we      (wb_we),
    .wb_adr     (wb_adr),
    .wb_sel     (wb_sel),
    .wb_dat_o   (wb_dat_o),
    .wb_stall   (wb_stall),
    .wb_ack     (wb_ack),
    .wb_err     (wb_err),
    .wb_dat_i   (wb_dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge; inputs change here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sample point for comb outputs, mid-cycle
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] rdata, input logic err);
    exp_q.push_back({err, rdata});
    n_push++;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] d);
    core_req   = 1'b1;
    core_we    = we;
    core_addr  = a;
    core_be    = be;
    core_wdata = d;
  endtask

  // scoreboard: every response must match the oldest queued expectation
  always @(negedge clk) begin
    if (core_rvalid === 1'b1) begin
      logic [32:0] e;
      n_rv++;
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL rvalid_unexpected observed=%0h expected=none", {core_err, core_rdata});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_data_err", 64'({core_err, core_rdata}), 64'(e));
      end
    end
  end

  initial begin
    rst_n = 1'b0; core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_be = '0;
    core_wdata = '0; wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;

    // reset state
    step(); step();
    mid();
    chk("rst_cyc", 64'(wb_cyc), 64'(0));
    chk("rst_stb", 64'(wb_stb), 64'(0));
    chk("rst_rvalid", 64'(core_rvalid), 64'(0));
    chk("rst_fields", 64'({wb_we, wb_sel, wb_adr}), 64'(0));
    chk("rst_dat", 64'(wb_dat_o), 64'(0));
    chk("rst_cnt", 64'(dut.r_out_cnt), 64'(0));
    step(); rst_n = 1'b1;

    // single read
    step(); drive_req(1'b0, 32'h10, 4'hF, 32'h0);
    mid(); chk("t1_gnt_N", 64'(core_gnt), 64'(1)); push(32'hDEADBEEF, 1'b0);
    step(); core_req = 1'b0;
    mid(); chk("t1_stb_N1", 64'({wb_cyc, wb_stb, wb_we}), 64'(3'b110));
    chk("t1_adr", 64'(wb_adr), 64'(32'h10));
    chk("t1_norv_N1", 64'(core_rvalid), 64'(0));
    step(); wb_ack = 1'b1; wb_dat_i = 32'hDEADBEEF;
    mid(); chk("t1_rv_N2", 64'(core_rvalid), 64'(1));
    chk("t1_stb_low_N2", 64'(wb_stb), 64'(0));
    step(); wb_ack = 1'b0; wb_dat_i = '0;
    mid(); chk("t1_cyc_N3", 64'(wb_cyc), 64'(0));

    // back-to-back writes with 3 stall cycles
    step(); drive_req(1'b1, 32'h100, 4'hF, 32'h11111111);
    mid(); chk("t2_gnt0", 64'(core_gnt), 64'(1)); push(32'h0, 1'b0);
    step(); drive_req(1'b1, 32'h104, 4'h3, 32'h22222222); wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("t2_gnt_stall", 64'(core_gnt), 64'(0));
      chk("t2_hold", 64'({wb_we, wb_sel, wb_adr}), 64'({1'b1, 4'hF, 32'h100}));
      chk("t2_hold_dat", 64'(wb_dat_o), 64'(32'h11111111));
      if (i < 2) step();
    end
    step(); wb_stall = 1'b0;
    mid(); chk("t2_gnt1", 64'(core_gnt), 64'(1)); push(32'h0, 1'b0);
    step(); core_req = 1'b0; wb_ack = 1'b1;
    mid(); chk("t2_second", 64'({wb_sel, wb_adr}), 64'({4'h3, 32'h104}));
    chk("t2_second_dat", 64'(wb_dat_o), 64'(32'h22222222));
    chk("t2_rv1", 64'(core_rvalid), 64'(1));
    step();
    mid(); chk("t2_rv2", 64'(core_rvalid), 64'(1));
    step(); wb_ack = 1'b0;
    mid(); chk("t2_cyc_end", 64'(wb_cyc), 64'(0));

    // outstanding limit
    step(); drive_req(1'b0, 32'h200, 4'hF, 32'h0);
    mid(); chk("t3_gnt_a", 64'(core_gnt), 64'(1)); push(32'hA0A0A0A0, 1'b0);
    step(); drive_req(1'b0, 32'h204, 4'hF, 32'h0);
    mid(); chk("t3_gnt_b", 64'(core_gnt), 64'(1)); push(32'hB1B1B1B1, 1'b0);
    step(); drive_req(1'b0, 32'h208, 4'hF, 32'h0);
    mid(); chk("t3_nognt_c0", 64'(core_gnt), 64'(0));
    step();
    mid(); chk("t3_nognt_c1", 64'(core_gnt), 64'(0));
    chk("t3_cnt2", 64'(dut.r_out_cnt), 64'(2));
    step(); wb_ack = 1'b1; wb_dat_i = 32'hA0A0A0A0;
    mid(); chk("t3_nognt_ack", 64'(core_gnt), 64'(0));
    chk("t3_rv_a", 64'(core_rvalid), 64'(1));
    step(); wb_dat_i = 32'hB1B1B1B1;
    mid(); chk("t3_gnt_c", 64'(core_gnt), 64'(1)); push(32'hC2C2C2C2, 1'b0);
    chk("t3_cnt1", 64'(dut.r_out_cnt), 64'(1));
    step(); core_req = 1'b0; wb_ack = 1'b0; wb_dat_i = '0;
    mid(); chk("t3_cnt0_stb", 64'({dut.r_out_cnt, wb_stb}), 64'({2'd0, 1'b1}));
    step(); wb_ack = 1'b1; wb_dat_i = 32'hC2C2C2C2;
    mid(); chk("t3_rv_c", 64'(core_rvalid), 64'(1));
    step(); wb_ack = 1'b0; wb_dat_i = '0;
    mid(); chk("t3_cyc_end", 64'(wb_cyc), 64'(0));

    // error response, then a normal one
    step(); drive_req(1'b0, 32'h2000, 4'hF, 32'h0);
    mid(); chk("t4_gnt", 64'(core_gnt), 64'(1)); push(32'h0, 1'b1);
    step(); core_req = 1'b0;
    step(); wb_err = 1'b1;
    mid(); chk("t4_rv_err", 64'({core_rvalid, core_err}), 64'(2'b11));
    step(); wb_err = 1'b0; drive_req(1'b0, 32'h2004, 4'hF, 32'h0);
    mid(); chk("t4_gnt2", 64'(core_gnt), 64'(1)); push(32'h12345678, 1'b0);
    step(); core_req = 1'b0;
    step(); wb_ack = 1'b1; wb_dat_i = 32'h12345678;
    mid(); chk("t4_rv_ok", 64'({core_rvalid, core_err}), 64'(2'b10));
    step(); wb_ack = 1'b0; wb_dat_i = '0;

    // ack and err together: one error termination
    drive_req(1'b0, 32'h2008, 4'hF, 32'h0);
    mid(); chk("t4b_gnt", 64'(core_gnt), 64'(1)); push(32'h0, 1'b1);
    step(); core_req = 1'b0;
    step(); wb_ack = 1'b1; wb_err = 1'b1;
    mid(); chk("t4b_rv", 64'({core_rvalid, core_err}), 64'(2'b11));
    step(); wb_ack = 1'b0; wb_err = 1'b0;
    mid(); chk("t4b_cnt0", 64'({wb_cyc, dut.r_out_cnt}), 64'(0));

    // spurious ack while idle
    step(); wb_ack = 1'b1; wb_dat_i = 32'hBAD0BAD0;
    mid(); chk("t5_norv", 64'({core_rvalid, wb_cyc}), 64'(0));
    step(); wb_ack = 1'b0; wb_dat_i = '0;
    mid(); chk("t5_cnt0", 64'(dut.r_out_cnt), 64'(0));

    // reset with one outstanding and one stalled
    step(); drive_req(1'b0, 32'h300, 4'hF, 32'h0);
    mid(); chk("t6_gnt_a", 64'(core_gnt), 64'(1));
    step(); drive_req(1'b0, 32'h304, 4'hF, 32'h0);
    mid(); chk("t6_gnt_b", 64'(core_gnt), 64'(1));
    step(); core_req = 1'b0; wb_stall = 1'b1;
    mid(); chk("t6_pre", 64'({wb_stb, dut.r_out_cnt}), 64'({1'b1, 2'd1}));
    rst_n = 1'b0;
    step(); rst_n = 1'b1; wb_stall = 1'b0; wb_ack = 1'b1; wb_dat_i = 32'hDEAD0000;
    mid(); chk("t6_post", 64'({wb_cyc, wb_stb, dut.r_out_cnt}), 64'(0));
    chk("t6_late_ack", 64'(core_rvalid), 64'(0));
    chk("t6_adr0", 64'(wb_adr), 64'(0));
    step(); wb_ack = 1'b0; wb_dat_i = '0; drive_req(1'b0, 32'h400, 4'hF, 32'h0);
    mid(); chk("t6_gnt_new", 64'(core_gnt), 64'(1)); push(32'h55AA55AA, 1'b0);
    step(); core_req = 1'b0;
    mid(); chk("t6_adr_new", 64'(wb_adr), 64'(32'h400));
    step(); wb_ack = 1'b1; wb_dat_i = 32'h55AA55AA;
    mid(); chk("t6_rv_new", 64'(core_rvalid), 64'(1));
    step(); wb_ack = 1'b0; wb_dat_i = '0;
    mid(); chk("t6_cyc_end", 64'(wb_cyc), 64'(0));

    step(); step();
    chk("rv_count", 64'(n_rv), 64'(n_push));
    chk("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_core2wb_bridge
